// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU op codes, R-type func codes and sequencer state enum shared by the decoder and its wrapper
package alu_ctrl_pkg;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_DIV = 4'b1011;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_NOP = 4'b1111;
    localparam logic [5:0] F_ADD = 6'b000000;
    localparam logic [5:0] F_SUB = 6'b000010;
    localparam logic [5:0] F_AND = 6'b000100;
    localparam logic [5:0] F_OR  = 6'b000101;
    localparam logic [5:0] F_XOR = 6'b000110;
    localparam logic [5:0] F_NOR = 6'b000111;
    localparam logic [5:0] F_SLT = 6'b001010;
    localparam logic [5:0] F_SLL = 6'b010000;
    localparam logic [5:0] F_SRL = 6'b010001;
    localparam logic [5:0] F_MUL = 6'b011000;
    localparam logic [5:0] F_DIV = 6'b011010;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/alu_func_decode.sv
// alu_func_decode: combinational (alu_op, func) -> operation, illegal flag, is_multi (MUL/DIV)
module alu_func_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W = 6,
    parameter int OP_W   = 4
) (
    input  logic [1:0]        alu_op,
    input  logic [FUNC_W-1:0] func,
    output logic [OP_W-1:0]   operation,
    output logic              illegal,
    output logic              is_multi
);
    logic [3:0] op;
    always_comb begin
        op = OP_NOP;
        illegal = 1'b0;
        case (alu_op)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (func)
                    FUNC_W'(F_ADD): op = OP_ADD;
                    FUNC_W'(F_SUB): op = OP_SUB;
                    FUNC_W'(F_AND): op = OP_AND;
                    FUNC_W'(F_OR):  op = OP_OR;
                    FUNC_W'(F_XOR): op = OP_XOR;
                    FUNC_W'(F_NOR): op = OP_NOR;
                    FUNC_W'(F_SLT): op = OP_SLT;
                    FUNC_W'(F_SLL): op = OP_SLL;
                    FUNC_W'(F_SRL): op = OP_SRL;
                    FUNC_W'(F_MUL): op = OP_MUL;
                    FUNC_W'(F_DIV): op = OP_DIV;
                    default:        illegal = 1'b1;
                endcase
            end
            default: begin
                case (func[2:0])
                    3'b000:  op = OP_AND;
                    3'b001:  op = OP_OR;
                    3'b010:  op = OP_XOR;
                    3'b011:  op = OP_SLT;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end
    assign operation = OP_W'(op);
    assign is_multi  = (op == OP_MUL) || (op == OP_DIV);
endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq: registered ALUOp/func decoder with valid/ready handshake, MUL/DIV sequencing (md_start, stall) and flush
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W     = 6,
    parameter int OP_W       = 4,
    parameter int MUL_CYCLES = 8,
    parameter int DIV_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [FUNC_W-1:0] func,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   operation,
    output logic              illegal,
    output logic              md_start,
    output logic              stall
);
    localparam int MAX_C = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_C) + 1;
    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [OP_W-1:0]   op_n, dec_op;
    logic              ill_n, ov_n, mds_n, dec_ill, dec_multi, accept;
    alu_func_decode #(.FUNC_W(FUNC_W), .OP_W(OP_W)) u_dec (
        .alu_op    (alu_op),
        .func      (func),
        .operation (dec_op),
        .illegal   (dec_ill),
        .is_multi  (dec_multi)
    );
    assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign stall    = (state == EXEC);
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = operation;
        ill_n   = illegal;
        ov_n    = out_valid && !out_ready;
        mds_n   = 1'b0;
        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
            op_n    = OP_W'(OP_NOP);
            ill_n   = 1'b0;
            ov_n    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_n    = dec_op;
                        ill_n   = dec_ill;
                        ov_n    = !dec_multi;
                        mds_n   = dec_multi;
                        state_n = dec_multi ? EXEC : IDLE;
                        cnt_n   = !dec_multi ? cnt :
                                  (dec_op == OP_W'(OP_MUL)) ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                    end
                end
                EXEC: begin
                    state_n = (cnt == '0) ? DONE : EXEC;
                    ov_n    = (cnt == '0);
                    cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
                end
                default: state_n = out_ready ? IDLE : DONE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            operation <= OP_W'(OP_NOP);
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            md_start  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            operation <= op_n;
            illegal   <= ill_n;
            out_valid <= ov_n;
            md_start  <= mds_n;
        end
    end
endmodule
